// File: rtl/weight_fifo_pkg.sv
// Shared types and helpers for the weight FIFO write-side controller.
package weight_fifo_pkg;

  // Controller state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wfi_state_e;

  // Default weight-memory read latency
  localparam int WFI_RD_LAT = 1;

  // Bits needed to hold a count in 0..n-1 (never less than one bit)
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lane_skew_delay.sv
// Per-lane FIFO write enable generation: lane i sees the data-valid bit
// delayed by i cycles when skewed, or undelayed when all lanes run together.
module lane_skew_delay #(
  parameter int FIFO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  vld,
  input  logic                  skew,
  output logic [FIFO_WIDTH-1:0] en
);

  generate
    if (FIFO_WIDTH == 1) begin : g_single
      assign en = vld;
    end else begin : g_sr
      // sr[i] is vld delayed i cycles. Fed only while skewed so an unskewed
      // burst never leaves stale bits for a following skewed burst.
      logic [FIFO_WIDTH-1:1] sr;

      // Diagonal delay line, flushed synchronously on abort
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          sr <= '0;
        end else if (clr) begin
          sr <= '0;
        end else begin
          sr[1] <= vld & skew;
          for (int i = 2; i < FIFO_WIDTH; i++) sr[i] <= sr[i-1];
        end
      end

      // Lane select: tap i of the delay line or the common valid
      always_comb begin
        en    = '0;
        en[0] = vld;
        for (int i = 1; i < FIFO_WIDTH; i++) en[i] = skew ? sr[i] : vld;
      end
    end
  endgenerate

endmodule

// File: rtl/weight_fifo_in_ctrl.sv
// Write-side controller for the weight FIFO array: accepts a load command,
// issues a burst of weight-memory reads and raises per-lane FIFO write
// enables aligned to the memory read latency, optionally diagonally skewed.
module weight_fifo_in_ctrl
  import weight_fifo_pkg::*;
#(
  parameter  int FIFO_WIDTH = 16,
  parameter  int MAX_DEPTH  = 16,
  parameter  int ADDR_WIDTH = 10,
  parameter  int RD_LAT     = WFI_RD_LAT,
  localparam int LEN_WIDTH  = $clog2(MAX_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic                  cfg_skew,
  input  logic                  abort,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [FIFO_WIDTH-1:0] fifo_en,
  output logic                  busy,
  output logic                  done
);

  // Drain counter must hold RD_LAT + (FIFO_WIDTH-1) - 1
  localparam int DW = cnt_w(RD_LAT + FIFO_WIDTH);

  wfi_state_e            state;
  logic [LEN_WIDTH-1:0]  rem;        // issues left after the current one
  logic [DW-1:0]         drain_cnt;  // cycles left after the current one
  logic                  skew_q;
  logic [LEN_WIDTH-1:0]  lc_in;
  logic                  flush;
  logic [RD_LAT-1:0]     vld_pipe;
  logic                  dv;

  assign start_ready = (state == IDLE);
  assign flush       = abort && (state != IDLE);

  // Requested length clamped to the FIFO depth
  assign lc_in = (cfg_len > LEN_WIDTH'(MAX_DEPTH)) ? LEN_WIDTH'(MAX_DEPTH) : cfg_len;

  // Burst sequencer with registered read strobe, address, busy and done
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rem         <= '0;
      drain_cnt   <= '0;
      skew_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // abort is ignored here; a start in the same cycle still wins
          if (start_valid) begin
            skew_q <= cfg_skew;
            if (lc_in != '0) begin
              state       <= ISSUE;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= cfg_base;
              rem         <= lc_in - LEN_WIDTH'(1);
              busy        <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (abort) begin
            state     <= IDLE;
            mem_rd_en <= 1'b0;
            busy      <= 1'b0;
          end else if (rem == '0) begin
            // Drain covers the read latency plus the skew ramp
            state     <= DRAIN;
            mem_rd_en <= 1'b0;
            drain_cnt <= DW'(RD_LAT - 1) + (skew_q ? DW'(FIFO_WIDTH - 1) : DW'(0));
          end else begin
            mem_rd_addr <= mem_rd_addr + ADDR_WIDTH'(1);
            rem         <= rem - LEN_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (drain_cnt == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          mem_rd_en <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  // Read-latency delay of the read strobe; flushing drops in-flight reads
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= mem_rd_en;
      for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign dv = vld_pipe[RD_LAT-1];

  lane_skew_delay #(
    .FIFO_WIDTH (FIFO_WIDTH)
  ) u_skew (
    .clk  (clk),
    .rstn (rstn),
    .clr  (flush),
    .vld  (dv),
    .skew (skew_q),
    .en   (fifo_en)
  );

endmodule

// File: tb/tb_weight_fifo_in_ctrl.sv
// Bench for weight_fifo_in_ctrl: each command pushes its expected per-cycle
// output trace, derived from the burst timing formulas, onto a scoreboard
// that is popped and compared once per cycle.
module tb_weight_fifo_in_ctrl;

  localparam int FW = 16;
  localparam int MD = 16;
  localparam int AW = 10;
  localparam int RL = 1;
  localparam int LW = $clog2(MD) + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [AW-1:0] cfg_base = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_skew = 1'b0;
  logic          abort = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [FW-1:0] fifo_en;
  logic          busy;
  logic          done;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [FW-1:0] fe;
    logic          busy;
    logic          done;
    logic          rdy;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  weight_fifo_in_ctrl #(
    .FIFO_WIDTH (FW),
    .MAX_DEPTH  (MD),
    .ADDR_WIDTH (AW),
    .RD_LAT     (RL)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .cfg_base    (cfg_base),
    .cfg_len     (cfg_len),
    .cfg_skew    (cfg_skew),
    .abort       (abort),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .fifo_en     (fifo_en),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs in cycle k of a burst (handshake in cycle 0)
  function automatic exp_t model(input int k, input int lc, input int s,
                                 input logic [AW-1:0] base, input bit skw);
    exp_t e;
    e.rd   = (k >= 1) && (k <= lc);
    e.addr = base + AW'(k - 1);
    e.fe   = '0;
    for (int i = 0; i < FW; i++)
      e.fe[i] = (k >= 1 + RL + (skw ? i : 0)) && (k <= lc + RL + (skw ? i : 0));
    e.busy = (lc > 0) && (k >= 1) && (k <= lc + RL + s);
    e.done = (lc == 0) ? (k == 1) : (k == lc + RL + s + 1);
    e.rdy  = 1'b0;
    return e;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_addr"},  mem_rd_addr, 0);
    chk({tag, "_fifo_en"}, fifo_en, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_ready"}, start_ready, 1);
  endtask

  // Called at a negedge with the DUT idle. abort_at: 0 none, -1 together with
  // the start, >0 cycle in which abort is held. rst_at: cycle of async reset.
  task automatic run_cmd(input logic [AW-1:0] base, input int len, input bit skw,
                         input int abort_at, input int rst_at);
    int   lc = (len > MD) ? MD : len;
    int   s  = skw ? FW - 1 : 0;
    int   n  = (lc == 0) ? 1 : lc + RL + s + 1;
    exp_t e;
    chk("ready_idle", start_ready, 1);
    start_valid = 1'b1;
    cfg_base    = base;
    cfg_len     = LW'(len);
    cfg_skew    = skw;
    abort       = (abort_at < 0);
    for (int k = 1; k <= n; k++) begin
      if (abort_at > 0 && k > abort_at) begin
        e.rd = 1'b0; e.addr = '0; e.fe = '0; e.busy = 1'b0; e.done = 1'b0; e.rdy = 1'b1;
        sb.push_back(e);
        break;
      end
      sb.push_back(model(k, lc, s, base, skw));
    end
    for (int c = 1; sb.size() > 0; c++) begin
      @(negedge clk);
      start_valid = 1'b0;
      abort       = 1'b0;
      cfg_base    = AW'($urandom);
      cfg_len     = LW'($urandom);
      cfg_skew    = 1'($urandom);
      e = sb.pop_front();
      chk($sformatf("rd_en@%0d", c), mem_rd_en, e.rd);
      if (e.rd) chk($sformatf("addr@%0d", c), mem_rd_addr, e.addr);
      chk($sformatf("fifo_en@%0d", c), fifo_en, e.fe);
      chk($sformatf("busy@%0d", c), busy, e.busy);
      chk($sformatf("done@%0d", c), done, e.done);
      chk($sformatf("ready@%0d", c), start_ready, e.rdy);
      if (c == abort_at) abort = 1'b1;
      if (c == rst_at) begin
        sb.delete();
        #2 rstn = 1'b0;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        chk_reset_outputs("held_rst");
        rstn = 1'b1;
      end
    end
    if (abort_at <= 0 && rst_at == 0) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset_hold");
    rstn = 1'b1;
    @(negedge clk);

    run_cmd(10'h3F0, 16, 1'b0, 0, 0);   // full burst, lanes together
    run_cmd(10'h3F0, 4,  1'b1, 0, 0);   // skewed ramp
    run_cmd(10'h3FE, 4,  1'b0, 0, 0);   // address wrap
    run_cmd(10'h100, 31, 1'b0, 0, 0);   // length clamp to 16
    run_cmd(10'h055, 0,  1'b0, 0, 0);   // empty burst
    run_cmd(10'h055, 0,  1'b1, 0, 0);   // empty skewed burst
    run_cmd(10'h200, 8,  1'b1, 6, 0);   // abort during issue
    run_cmd(10'h080, 5,  1'b1, -1, 0);  // abort with start in idle
    run_cmd(10'h0C0, 3,  1'b1, 10, 0);  // abort during drain
    run_cmd(10'h3F0, 4,  1'b1, 0, 9);   // async reset during drain
    run_cmd(10'h010, 3,  1'b1, 0, 0);   // fresh burst after reset

    // abort alone in idle does nothing
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_ready", start_ready, 1);
    chk("idle_abort_busy", busy, 0);

    for (int r = 0; r < 6; r++)
      run_cmd(AW'($urandom), int'($urandom_range(0, 20)), 1'($urandom), 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
